// File: rtl/bch_pkg.sv
// Shared GF(2^13) definitions for the t=8 BCH decoder: field width, correction capability,
// element type and Chien search FSM states.
package bch_pkg;

  localparam int M = 13;
  localparam int T = 8;

  typedef logic [M-1:0] gf_elem_t;

  // Low terms of x^13 + x^4 + x^3 + x + 1
  localparam gf_elem_t PRIM_POLY = 13'h001B;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } chien_state_t;

  function automatic gf_elem_t gf_mul_alpha(input gf_elem_t x);
    return {x[M-2:0], 1'b0} ^ (x[M-1] ? PRIM_POLY : '0);
  endfunction

endpackage

// File: rtl/gf_alpha_pow_mul.sv
// Combinational multiply of a field element by the constant alpha^K.
// Zero latency; purely combinational, so there is no backpressure.
module gf_alpha_pow_mul
  import bch_pkg::*;
#(
  parameter int K = 1
) (
  input  gf_elem_t a,
  output gf_elem_t y
);

  always_comb begin
    gf_elem_t acc;
    acc = a;
    for (int i = 0; i < K; i++) acc = gf_mul_alpha(acc);
    y = acc;
  end

endmodule

// File: rtl/bch_chien_search.sv
// Chien search: loads the error locator serially, then tests one position per cycle.
// Root result is registered one cycle after evaluation; lam_vld during the search is dropped and flagged.
module bch_chien_search #(
  parameter int M = bch_pkg::M,
  parameter int T = bch_pkg::T,
  parameter int N = 8191
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] lam_in,
  input  logic         lam_vld,
  output logic         busy,
  output logic         overrun,
  output logic         root_vld,
  output logic [12:0]  root_idx,
  output logic         root_flag,
  output logic         done,
  output logic [4:0]   err_cnt,
  output logic         fail
);
  import bch_pkg::*;

  localparam int KW = $clog2(T + 1);
  localparam logic [12:0] LAST_POS = 13'(N - 1);

  chien_state_t   state;
  logic [M-1:0]   r      [0:T];
  logic [M-1:0]   r_next [0:T];
  logic [KW-1:0]  k;
  logic [KW-1:0]  deg;
  logic [12:0]    j;
  logic [M-1:0]   sum;

  // r[k] carries lambda_k * alpha^(k*j); term 0 never changes
  assign r_next[0] = r[0];
  for (genvar g = 1; g <= T; g++) begin : g_mul
    gf_alpha_pow_mul #(.K(g)) u_mul (
      .a (r[g]),
      .y (r_next[g])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i <= T; i++) sum = sum ^ r[i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      for (int i = 0; i <= T; i++) r[i] <= '0;
      k         <= '0;
      deg       <= '0;
      j         <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      root_vld  <= 1'b0;
      root_idx  <= '0;
      root_flag <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= '0;
      fail      <= 1'b0;
    end else begin
      overrun  <= 1'b0;
      root_vld <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (lam_vld) begin
            r[0]    <= lam_in;
            k       <= KW'(1);
            deg     <= '0;
            err_cnt <= '0;
            fail    <= 1'b0;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (lam_vld) begin
            r[k] <= lam_in;
            if (lam_in != '0) deg <= k;
            if (k == KW'(T)) begin
              j     <= '0;
              state <= SEARCH;
            end else begin
              k <= k + KW'(1);
            end
          end else begin
            // Short load: discard and wait for a fresh lambda_0
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SEARCH: begin
          for (int i = 0; i <= T; i++) r[i] <= r_next[i];
          root_vld  <= 1'b1;
          root_idx  <= j;
          root_flag <= (sum == '0);
          if (sum == '0 && err_cnt != 5'd31) err_cnt <= err_cnt + 5'd1;
          overrun   <= lam_vld;
          if (j == LAST_POS) state <= DONE;
          else               j     <= j + 13'd1;
        end
        DONE: begin
          done  <= 1'b1;
          fail  <= (r[0] == '0) || (err_cnt != 5'(deg));
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_chien_search.sv
// Directed bench for bch_chien_search: known locator polynomials with hand-derived roots.
module tb_bch_chien_search;

  typedef logic [12:0] coef_t;

  logic        clk;
  logic        reset;
  logic [12:0] lam_in;
  logic        lam_vld;
  logic        busy, overrun, root_vld, root_flag, done, fail;
  logic [12:0] root_idx;
  logic [4:0]  err_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // Observations gathered by run_search
  int   first_root, n_vld, idx_err, n_flag, done_cyc, ovr_cnt, post_rst_act;
  int   flag_idx [8];
  logic busy_c1, busy_pre, busy_at_done, fail_at_done, rst_zero;
  logic [4:0] cnt_at_done;

  bch_chien_search dut (
    .clk       (clk),
    .reset     (reset),
    .lam_in    (lam_in),
    .lam_vld   (lam_vld),
    .busy      (busy),
    .overrun   (overrun),
    .root_vld  (root_vld),
    .root_idx  (root_idx),
    .root_flag (root_flag),
    .done      (done),
    .err_cnt   (err_cnt),
    .fail      (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loads lambda, then watches the search; optional overrun pulse or reset at a given root_idx.
  task automatic run_search(input coef_t c [9], input int inj_idx, input int rst_idx);
    logic pulse;
    pulse = 1'b0;
    first_root = -1; n_vld = 0; idx_err = 0; n_flag = 0; done_cyc = -1; ovr_cnt = 0;
    post_rst_act = 0; busy_c1 = 1'b0; busy_pre = 1'b0; busy_at_done = 1'b1;
    fail_at_done = 1'bx; cnt_at_done = 'x; rst_zero = 1'b0;
    for (int i = 0; i < 8; i++) flag_idx[i] = -1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      lam_vld = 1'b1;
      lam_in  = c[i];
    end
    for (int cyc = 1; cyc <= 9000; cyc++) begin
      @(negedge clk);
      if (cyc == 1 || pulse) begin
        lam_vld = 1'b0;
        lam_in  = '0;
        pulse   = 1'b0;
      end
      if (cyc == 1) busy_c1 = busy;
      if (overrun) ovr_cnt++;
      if (root_vld) begin
        if (first_root < 0) first_root = cyc;
        if (root_idx != 13'(n_vld)) idx_err++;
        n_vld++;
        if (root_flag) begin
          if (n_flag < 8) flag_idx[n_flag] = int'(root_idx);
          n_flag++;
        end
      end
      if (done) begin
        done_cyc     = cyc;
        cnt_at_done  = err_cnt;
        fail_at_done = fail;
        busy_at_done = busy;
        break;
      end
      if (rst_idx >= 0 && root_vld && int'(root_idx) == rst_idx) begin
        reset = 1'b1;
        #1;
        rst_zero = ({busy, overrun, root_vld, root_idx, root_flag, done, err_cnt, fail} == '0);
        @(negedge clk);
        reset = 1'b0;
        for (int q = 0; q < 40; q++) begin
          @(negedge clk);
          if (done || root_vld || busy) post_rst_act++;
        end
        return;
      end
      if (inj_idx >= 0 && root_vld && int'(root_idx) == inj_idx) begin
        lam_vld = 1'b1;
        lam_in  = 13'h1234;
        pulse   = 1'b1;
      end
      busy_pre = busy;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; lam_vld = 1'b0; lam_in = '0;
    #2;
    n_chk++;
    if ({busy, overrun, root_vld, root_idx, root_flag, done, err_cnt, fail} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%b ovr=%b rv=%b idx=%0d rf=%b done=%b cnt=%0d fail=%b, expected all 0",
                         busy, overrun, root_vld, root_idx, root_flag, done, err_cnt, fail);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_no_roots();
    coef_t c [9] = '{13'h0001, 0, 0, 0, 0, 0, 0, 0, 0};
    run_search(c, -1, -1);
    n_chk++; if (done_cyc !== 8193) begin n_fail++; $display("FAIL no_roots_done_cycle: got %0d expected 8193", done_cyc); end
    n_chk++; if (first_root !== 2) begin n_fail++; $display("FAIL first_root_latency: got %0d expected 2", first_root); end
    n_chk++; if (n_vld !== 8191) begin n_fail++; $display("FAIL root_vld_count: got %0d expected 8191", n_vld); end
    n_chk++; if (idx_err !== 0) begin n_fail++; $display("FAIL root_idx_sequence: got %0d errors expected 0", idx_err); end
    n_chk++; if (n_flag !== 0) begin n_fail++; $display("FAIL no_roots_flags: got %0d expected 0", n_flag); end
    n_chk++; if (cnt_at_done !== 5'd0) begin n_fail++; $display("FAIL no_roots_err_cnt: got %0d expected 0", cnt_at_done); end
    n_chk++; if (fail_at_done !== 1'b0) begin n_fail++; $display("FAIL no_roots_fail: got %b expected 0", fail_at_done); end
    n_chk++; if (busy_c1 !== 1'b1) begin n_fail++; $display("FAIL busy_in_search: got %b expected 1", busy_c1); end
    n_chk++; if (busy_pre !== 1'b1) begin n_fail++; $display("FAIL busy_before_done: got %b expected 1", busy_pre); end
    n_chk++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b expected 0", busy_at_done); end
    n_chk++; if (ovr_cnt !== 0) begin n_fail++; $display("FAIL spurious_overrun: got %0d expected 0", ovr_cnt); end
  endtask

  task automatic test_abort();
    int rv = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); lam_vld = 1'b1; lam_in = 13'h0001;
    end
    @(negedge clk); lam_vld = 1'b0; lam_in = '0;
    for (int q = 0; q < 30; q++) begin
      @(negedge clk);
      if (root_vld || done) rv++;
    end
    n_chk++; if (rv !== 0) begin n_fail++; $display("FAIL abort_activity: got %0d root/done cycles expected 0", rv); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_root();
    coef_t c [9] = '{13'h0001, 13'h0001, 0, 0, 0, 0, 0, 0, 0};
    run_search(c, -1, -1);
    n_chk++; if (n_flag !== 1) begin n_fail++; $display("FAIL single_root_count: got %0d expected 1", n_flag); end
    n_chk++; if (flag_idx[0] !== 0) begin n_fail++; $display("FAIL single_root_idx: got %0d expected 0", flag_idx[0]); end
    n_chk++; if (cnt_at_done !== 5'd1) begin n_fail++; $display("FAIL single_root_err_cnt: got %0d expected 1", cnt_at_done); end
    n_chk++; if (fail_at_done !== 1'b0) begin n_fail++; $display("FAIL single_root_fail: got %b expected 0", fail_at_done); end
  endtask

  task automatic test_two_roots(input string tag, input int inj_idx);
    coef_t c [9] = '{13'h0001, 13'h0408, 13'h001B, 0, 0, 0, 0, 0, 0};
    run_search(c, inj_idx, -1);
    n_chk++; if (done_cyc !== 8193) begin n_fail++; $display("FAIL %s_done_cycle: got %0d expected 8193", tag, done_cyc); end
    n_chk++; if (n_flag !== 2) begin n_fail++; $display("FAIL %s_root_count: got %0d expected 2", tag, n_flag); end
    n_chk++; if (flag_idx[0] !== 8181 || flag_idx[1] !== 8188) begin
      n_fail++; $display("FAIL %s_root_idx: got %0d,%0d expected 8181,8188", tag, flag_idx[0], flag_idx[1]);
    end
    n_chk++; if (cnt_at_done !== 5'd2) begin n_fail++; $display("FAIL %s_err_cnt: got %0d expected 2", tag, cnt_at_done); end
    n_chk++; if (fail_at_done !== 1'b0) begin n_fail++; $display("FAIL %s_fail: got %b expected 0", tag, fail_at_done); end
    n_chk++; if (ovr_cnt !== (inj_idx >= 0 ? 1 : 0)) begin
      n_fail++; $display("FAIL %s_overrun: got %0d expected %0d", tag, ovr_cnt, (inj_idx >= 0 ? 1 : 0));
    end
  endtask

  task automatic test_fail();
    coef_t c3 [9] = '{13'h0001, 13'h0001, 13'h0001, 0, 0, 0, 0, 0, 0};
    coef_t cz [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    // 1+x+x^2 has no roots: no element of order 3 exists since 8191 is prime
    run_search(c3, -1, -1);
    n_chk++; if (done_cyc !== 8193) begin n_fail++; $display("FAIL mismatch_done: got %0d expected 8193", done_cyc); end
    n_chk++; if (cnt_at_done !== 5'd0) begin n_fail++; $display("FAIL mismatch_err_cnt: got %0d expected 0", cnt_at_done); end
    n_chk++; if (fail_at_done !== 1'b1) begin n_fail++; $display("FAIL mismatch_fail: got %b expected 1", fail_at_done); end
    // All-zero lambda: every position is a root, so the count saturates
    run_search(cz, -1, -1);
    n_chk++; if (n_flag !== 8191) begin n_fail++; $display("FAIL zero_lambda_flags: got %0d expected 8191", n_flag); end
    n_chk++; if (cnt_at_done !== 5'd31) begin n_fail++; $display("FAIL zero_lambda_saturate: got %0d expected 31", cnt_at_done); end
    n_chk++; if (fail_at_done !== 1'b1) begin n_fail++; $display("FAIL zero_lambda_fail: got %b expected 1", fail_at_done); end
  endtask

  task automatic test_reset_mid_search();
    coef_t c [9] = '{13'h0001, 13'h0001, 0, 0, 0, 0, 0, 0, 0};
    run_search(c, -1, 4000);
    n_chk++; if (rst_zero !== 1'b1) begin n_fail++; $display("FAIL mid_reset_outputs: got %b expected 1 (all zero)", rst_zero); end
    n_chk++; if (post_rst_act !== 0) begin n_fail++; $display("FAIL mid_reset_activity: got %0d expected 0", post_rst_act); end
    n_chk++; if (done_cyc !== -1) begin n_fail++; $display("FAIL mid_reset_done: got %0d expected -1", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_no_roots();
    test_abort();
    test_single_root();
    test_two_roots("two_roots", -1);
    test_fail();
    test_two_roots("overrun", 100);
    test_reset_mid_search();
    test_two_roots("after_reset", -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
